// File: rtl/wbh_boot_req_gen.sv
// Soft-reboot request initiator: collects triggers, drives a stretched
// soft_boot_req and confirms acceptance by watching s_reset_n fall then rise.
module wbh_boot_req_gen #(
  parameter int REQ_HOLD = 16,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cfg_boot_en,
  input  logic       sw_boot_req,
  input  logic       wdt_boot_req,
  input  logic       clr_status,
  input  logic       s_reset_n_i,
  output logic       soft_boot_req,
  output logic       busy,
  output logic       boot_done,
  output logic       boot_timeout,
  output logic [1:0] boot_cause,
  output logic [7:0] boot_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] L_HOLD = CNT_W'(REQ_HOLD - 1);
  localparam logic [CNT_W-1:0] L_TOM1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] L_TO   = CNT_W'(TIMEOUT);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ack;
  logic             r_req;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout;
  logic [1:0]       r_cause;
  logic [7:0]       r_count;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_srst_d;

  logic             w_fall;
  logic             w_trig;
  logic             w_accept;
  logic [1:0]       w_cause;
  logic             w_ack;

  assign w_fall   = r_srst_d & ~r_sync2;
  assign w_trig   = sw_boot_req | wdt_boot_req;
  assign w_accept = (r_state == S_IDLE) & cfg_boot_en
                  & r_sync2 & w_trig;
  assign w_cause  = sw_boot_req ? 2'b01 : 2'b10;
  assign w_ack    = (r_ack | w_fall) & (r_cnt >= L_HOLD);

  // Bring the asynchronous soft reset into the clk domain, plus one delay stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_srst_d <= 1'b0;
    end else begin
      r_sync1  <= s_reset_n_i;
      r_sync2  <= r_sync1;
      r_srst_d <= r_sync2;
    end
  end

  // Handshake FSM with registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ack     <= 1'b0;
      r_req     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_cause   <= 2'b00;
      r_count   <= 8'd0;
    end else begin
      r_done <= 1'b0;
      if (clr_status) r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_req  <= 1'b0;
          r_busy <= 1'b0;
          if (w_accept) begin
            r_state <= S_REQ;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
            r_cause <= w_cause;
          end
        end
        S_REQ: begin
          if (r_cnt != L_TO) r_cnt <= r_cnt + CNT_W'(1);
          if (w_fall) r_ack <= 1'b1;
          if (w_ack) begin
            r_req   <= 1'b0;
            r_state <= S_WAIT;
          end else if (r_cnt == L_TOM1) begin
            r_req     <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_WAIT: begin
          // Level test: a rise that landed during the hold window is not lost
          if (r_sync2) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
            if (r_count != 8'hFF) r_count <= r_count + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign soft_boot_req = r_req;
  assign busy          = r_busy;
  assign boot_done     = r_done;
  assign boot_timeout  = r_timeout;
  assign boot_cause    = r_cause;
  assign boot_count    = r_count;

endmodule
